// File: rtl/serial_frame_pkg.sv
// Framing constants and receiver state encoding shared by both ends of the serial switch link.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   DATA_BITS = 4;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Recovers 4-bit switch frames (start, 4 data LSB-first, stop) from the serial line,
// sampling mid-bit and flagging low stop bits once per break.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int            TW      = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [1:0]    LAST_IX = 2'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state, w_state_next;
    logic [TW-1:0]        r_timer, w_timer_next;
    logic [1:0]           r_idx, w_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data, w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_frame_err, w_err_next;

    sync2 u_sync (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_idx       <= w_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_err_next;
        end
    end

    // The timer counts cycles since the last sample; a sample is taken when it reaches N-1.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer + TW'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_next = '0;
                if (w_rx_s == START_LVL) begin
                    w_state_next = START;
                    w_idx_next   = '0;
                end
            end
            START: begin
                if (r_timer == HALF_M1) begin
                    w_timer_next = '0;
                    w_state_next = (w_rx_s == START_LVL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (r_timer == FULL_M1) begin
                    w_timer_next        = '0;
                    w_shift_next[r_idx] = w_rx_s;
                    w_idx_next          = r_idx + 2'd1;
                    if (r_idx == LAST_IX) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (r_timer == FULL_M1) begin
                    w_timer_next = '0;
                    if (w_rx_s == STOP_LVL) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line recovers so a stuck-low line reports only once.
                w_timer_next = '0;
                if (w_rx_s == STOP_LVL) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed sequences, a vector table and a randomized frame stream.
module tb_serial_frame_rx;

    localparam int C   = 50;
    localparam int H   = C / 2;
    // rx edge -> 2 sync cycles -> stop sample at T + H + 5C -> registered pulse one cycle later
    localparam int LAT = 2 + H + 5 * C + 1;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic [3:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    serial_frame_rx #(.CLKS_PER_BIT(C)) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       v;
        logic       e;
        logic [3:0] d;
    } ev_t;

    ev_t obs[$];
    ev_t expq[$];

    always @(negedge sysclk) begin
        if (valid || frame_err) obs.push_back('{cyc, valid, frame_err, data});
    end

    typedef struct {
        logic [3:0] payload;
        logic       stop;
        logic       exp_v;
        logic       exp_e;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] p, input logic stop, output int fall);
        fall = cyc;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = p[i];
            tick(C);
        end
        rx = stop;
        tick(C);
        rx = 1'b1;
    endtask

    initial begin
        int f, f2, cnt;
        logic [3:0] last_good;
        logic [3:0] p;
        logic       s;
        int         gap;

        vecs[0] = '{4'h5, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[1] = '{4'h5, 1'b1, 1'b1, 1'b0, 4'h5};
        vecs[2] = '{4'hA, 1'b1, 1'b1, 1'b0, 4'hA};
        vecs[3] = '{4'h3, 1'b0, 1'b0, 1'b1, 4'hA};
        vecs[4] = '{4'hC, 1'b1, 1'b1, 1'b0, 4'hC};
        vecs[5] = '{4'h0, 1'b0, 1'b0, 1'b1, 4'hC};

        // Reset state
        tick(3);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(5);

        // Single good frame and its latency
        obs.delete();
        send_frame(4'hB, 1'b1, f);
        tick(5);
        check("good_count", obs.size(), 1);
        if (obs.size() >= 1) begin
            check("good_data", obs[0].d, 4'hB);
            check("good_err", obs[0].e, 0);
            check("good_latency", obs[0].cyc - f, LAT);
        end
        check("good_hold", data, 4'hB);

        // Back-to-back frames
        obs.delete();
        send_frame(4'hF, 1'b1, f);
        send_frame(4'h0, 1'b1, f2);
        tick(5);
        check("b2b_count", obs.size(), 2);
        if (obs.size() >= 2) begin
            check("b2b_d0", obs[0].d, 4'hF);
            check("b2b_d1", obs[1].d, 4'h0);
            check("b2b_spacing", obs[1].cyc - obs[0].cyc, 6 * C);
        end

        // Low stop bit with the line held low: one error, busy until line recovers
        obs.delete();
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = (4'h5 >> i) & 1'b1;
            tick(C);
        end
        rx = 1'b0;
        tick(C + 100);
        check("brk_count", obs.size(), 1);
        if (obs.size() >= 1) begin
            check("brk_err", obs[0].e, 1);
            check("brk_valid", obs[0].v, 0);
        end
        check("brk_data_kept", data, 4'h0);
        check("brk_busy_high", busy, 1);
        rx = 1'b1;
        tick(4);
        check("brk_busy_low", busy, 0);
        tick(C);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            obs.delete();
            send_frame(vecs[i].payload, vecs[i].stop, f);
            tick(C);
            check($sformatf("vec%0d_count", i), obs.size(), 1);
            if (obs.size() >= 1) begin
                check($sformatf("vec%0d_valid", i), obs[0].v, vecs[i].exp_v);
                check($sformatf("vec%0d_err", i), obs[0].e, vecs[i].exp_e);
                check($sformatf("vec%0d_cyc", i), obs[0].cyc - f, LAT);
            end
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_d);
        end

        // 10-cycle glitch on the idle line
        obs.delete();
        cnt = 0;
        for (int i = 0; i < 90; i++) begin
            rx = (i < 10) ? 1'b0 : 1'b1;
            tick(1);
            if (busy) cnt++;
        end
        check("glitch_events", obs.size(), 0);
        check("glitch_busy_len_ok", (cnt > 0 && cnt <= 27), 1);
        check("glitch_idle", busy, 0);

        // Reset during data bit 2
        obs.delete();
        rx = 1'b0;
        tick(C);
        rx = 1'b0;
        tick(C);
        rx = 1'b1;
        tick(C);
        rx = 1'b0;
        tick(H);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_err", frame_err, 0);
        tick(3);
        rx = 1'b1;
        rst_n = 1'b1;
        tick(2 * C);
        check("midrst_no_event", obs.size(), 0);
        send_frame(4'hA, 1'b1, f);
        tick(5);
        check("midrst_next_count", obs.size(), 1);
        if (obs.size() >= 1) check("midrst_next_data", obs[0].d, 4'hA);

        // Continuous stream of all-ones switch frames
        obs.delete();
        for (int i = 0; i < 10; i++) send_frame(4'hF, 1'b1, f);
        tick(5);
        check("loop_count", obs.size(), 10);
        for (int i = 0; i < obs.size() && i < 10; i++) begin
            check($sformatf("loop%0d_data", i), obs[i].d, 4'hF);
            check($sformatf("loop%0d_err", i), obs[i].e, 0);
        end

        // Randomized stream against a frame-level model
        obs.delete();
        expq.delete();
        last_good = 4'hF;
        for (int i = 0; i < 40; i++) begin
            p = 4'($urandom_range(15));
            s = ($urandom_range(4) != 0);
            send_frame(p, s, f);
            if (s) begin
                last_good = p;
                expq.push_back('{f + LAT, 1'b1, 1'b0, p});
            end else begin
                expq.push_back('{f + LAT, 1'b0, 1'b1, last_good});
            end
            gap = s ? $urandom_range(2 * C) : C + $urandom_range(C);
            if (gap > 0) tick(gap);
        end
        tick(C);
        check("rand_count", obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            check($sformatf("rand%0d_cyc", i), obs[i].cyc, expq[i].cyc);
            check($sformatf("rand%0d_kind", i), {obs[i].v, obs[i].e}, {expq[i].v, expq[i].e});
            check($sformatf("rand%0d_data", i), obs[i].d, expq[i].d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
